// File: rtl/logic_unit_pkg.sv
// Purpose: shared op encodings, sequencer state type and datapath width for the logic unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package logic_unit_pkg;

  localparam int WIDTH = 32;

  localparam logic OP_AND = 1'b0;
  localparam logic OP_OR  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    EXEC  = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/and_or.sv
// Purpose: 32-bit bitwise AND/OR unit, selection 0 = AND, 1 = OR.
// Latency: purely combinational.
// Backpressure: none.
// Ports: A, B operands; selection op select; result = A&B or A|B.
module and_or
  import logic_unit_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             selection,
  output logic [WIDTH-1:0] result
);

  assign result = (selection == OP_OR) ? (A | B) : (A & B);

endmodule

// File: rtl/logic_op_sequencer.sv
// Purpose: fetch two operands from the datapath bus, run and_or, hold result in Z for a valid/ready consumer.
// Latency: 4 edges from accepted start to z_valid with bus_valid held high; z_valid 2 edges after B is presented.
// Backpressure: bus side stalls in GET_A/GET_B until bus_valid; Z held in HOLD until z_ready.
// Ports: clock/clear (sync, active-high); start/op_sel request; bus_in/bus_valid/bus_ready operand
//        intake; z_out/z_valid/z_ready result handshake; busy status; op_count wrapping handshake count.
module logic_op_sequencer
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op_sel,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_valid,
  output logic             bus_ready,
  output logic [WIDTH-1:0] z_out,
  output logic             z_valid,
  input  logic             z_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic [WIDTH-1:0] result;

  and_or u_and_or (
    .A         (a_q),
    .B         (b_q),
    .selection (op_q),
    .result    (result)
  );

  // bus_ready, busy and z_valid are registered alongside the state so they
  // are pure state decodes with no input-to-output combinational path.
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_AND;
      z_out     <= '0;
      op_count  <= '0;
      z_valid   <= 1'b0;
      bus_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op_sel;
            state     <= GET_A;
            bus_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        GET_A: begin
          if (bus_valid) begin
            a_q   <= bus_in;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (bus_valid) begin
            b_q       <= bus_in;
            state     <= EXEC;
            bus_ready <= 1'b0;
          end
        end
        EXEC: begin
          z_out   <= result;
          state   <= HOLD;
          z_valid <= 1'b1;
        end
        HOLD: begin
          if (z_ready) begin
            op_count <= op_count + CNT_W'(1);
            z_valid  <= 1'b0;
            // A start coinciding with the handshake chains straight into the next fetch.
            if (start) begin
              op_q      <= op_sel;
              state     <= GET_A;
              bus_ready <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          z_valid   <= 1'b0;
          bus_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
